// File: rtl/mbist_repair_tbl.sv
// Deduplicated MBIST failing-address table: spare-row lookup for functional access, valid/ready dump.
// Lookup result one cycle after func_req; dump beats hold while dump_ready is low; table frozen in DUMP.
module mbist_repair_tbl #(
  parameter int BIST_ADDR_WD = 9,
  parameter int REP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    err_valid,
  input  logic [BIST_ADDR_WD-1:0] err_addr,
  input  logic                    func_req,
  input  logic [BIST_ADDR_WD-1:0] func_addr,
  output logic                    func_valid,
  output logic [BIST_ADDR_WD-1:0] func_addr_out,
  output logic                    func_spare,
  output logic [3:0]              func_spare_idx,
  output logic [4:0]              rep_cnt,
  output logic                    rep_full,
  output logic                    rep_ovf,
  output logic                    err_drop,
  input  logic                    dump_req,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [BIST_ADDR_WD-1:0] dump_data,
  output logic                    dump_last,
  output logic                    dump_busy
);
  typedef enum logic {S_IDLE, S_DUMP} state_t;

  state_t                  state_q, state_d;
  logic [BIST_ADDR_WD-1:0] ent_addr_q [REP_DEPTH];
  logic [BIST_ADDR_WD-1:0] ent_addr_d [REP_DEPTH];
  logic [REP_DEPTH-1:0]    ent_vld_q, ent_vld_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    drop_q, drop_d;
  logic [3:0]              ptr_q, ptr_d;
  logic                    func_valid_q, func_valid_d;
  logic [BIST_ADDR_WD-1:0] func_addr_q, func_addr_d;
  logic                    func_spare_q, func_spare_d;
  logic [3:0]              func_idx_q, func_idx_d;

  logic                    cap_hit, lk_hit, last_beat;
  logic [3:0]              lk_idx;
  logic [BIST_ADDR_WD-1:0] ptr_addr;

  // Entries are unique, so descending scan just makes the lowest index win deterministically.
  always_comb begin
    cap_hit  = 1'b0;
    lk_hit   = 1'b0;
    lk_idx   = 4'd0;
    ptr_addr = '0;
    for (int i = REP_DEPTH - 1; i >= 0; i--) begin
      if (ent_vld_q[i] && ent_addr_q[i] == err_addr) cap_hit = 1'b1;
      if (ent_vld_q[i] && ent_addr_q[i] == func_addr) begin
        lk_hit = 1'b1;
        lk_idx = 4'(i);
      end
      if (ptr_q == 4'(i)) ptr_addr = ent_addr_q[i];
    end
  end

  assign last_beat = (state_q == S_DUMP) && ({1'b0, ptr_q} == cnt_q - 5'd1);

  always_comb begin
    state_d      = state_q;
    ent_addr_d   = ent_addr_q;
    ent_vld_d    = ent_vld_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    ptr_d        = ptr_q;
    func_valid_d = func_req;
    func_addr_d  = func_addr_q;
    func_spare_d = func_spare_q;
    func_idx_d   = func_idx_q;

    if (func_req) begin
      func_addr_d  = func_addr;
      func_spare_d = lk_hit;
      func_idx_d   = lk_idx;
    end

    if (clear) begin
      state_d = S_IDLE;
      for (int i = 0; i < REP_DEPTH; i++) ent_addr_d[i] = '0;
      ent_vld_d = '0;
      cnt_d     = 5'd0;
      ovf_d     = 1'b0;
      drop_d    = 1'b0;
      ptr_d     = 4'd0;
    end else if (state_q == S_IDLE) begin
      if (err_valid && !cap_hit) begin
        if (cnt_q < 5'(REP_DEPTH)) begin
          for (int i = 0; i < REP_DEPTH; i++) begin
            if (cnt_q == 5'(i)) begin
              ent_addr_d[i] = err_addr;
              ent_vld_d[i]  = 1'b1;
            end
          end
          cnt_d = cnt_q + 5'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (dump_req && cnt_q != 5'd0) begin
        state_d = S_DUMP;
        ptr_d   = 4'd0;
      end
    end else begin
      if (err_valid) drop_d = 1'b1;
      if (dump_ready) begin
        if (last_beat) begin
          state_d = S_IDLE;
          ptr_d   = 4'd0;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < REP_DEPTH; i++) ent_addr_q[i] <= '0;
      ent_vld_q    <= '0;
      cnt_q        <= 5'd0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
      ptr_q        <= 4'd0;
      func_valid_q <= 1'b0;
      func_addr_q  <= '0;
      func_spare_q <= 1'b0;
      func_idx_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      ent_addr_q   <= ent_addr_d;
      ent_vld_q    <= ent_vld_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      ptr_q        <= ptr_d;
      func_valid_q <= func_valid_d;
      func_addr_q  <= func_addr_d;
      func_spare_q <= func_spare_d;
      func_idx_q   <= func_idx_d;
    end
  end

  assign func_valid     = func_valid_q;
  assign func_addr_out  = func_addr_q;
  assign func_spare     = func_spare_q;
  assign func_spare_idx = func_idx_q;
  assign rep_cnt        = cnt_q;
  assign rep_full       = (cnt_q == 5'(REP_DEPTH));
  assign rep_ovf        = ovf_q;
  assign err_drop       = drop_q;
  assign dump_busy      = (state_q == S_DUMP);
  assign dump_valid     = dump_busy;
  assign dump_data      = dump_busy ? ptr_addr : '0;
  assign dump_last      = last_beat;
endmodule

// File: tb/tb_mbist_repair_tbl.sv
// Bench for mbist_repair_tbl: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_mbist_repair_tbl;
  localparam int AW = 9;
  localparam int D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear, err_valid, func_req, dump_req, dump_ready;
  logic [AW-1:0] err_addr, func_addr;
  logic          func_valid, func_spare, rep_full, rep_ovf, err_drop;
  logic          dump_valid, dump_last, dump_busy;
  logic [AW-1:0] func_addr_out, dump_data;
  logic [3:0]    func_spare_idx;
  logic [4:0]    rep_cnt;

  mbist_repair_tbl #(.BIST_ADDR_WD(AW), .REP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .err_valid(err_valid), .err_addr(err_addr),
    .func_req(func_req), .func_addr(func_addr),
    .func_valid(func_valid), .func_addr_out(func_addr_out),
    .func_spare(func_spare), .func_spare_idx(func_spare_idx),
    .rep_cnt(rep_cnt), .rep_full(rep_full), .rep_ovf(rep_ovf), .err_drop(err_drop),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_last(dump_last), .dump_busy(dump_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the table is an ordered list of distinct addresses.
  logic [AW-1:0] m_tbl[$];
  bit            m_ovf, m_drop, m_dump, m_fvld, m_fspare;
  int            m_ptr, m_fidx, m_hit, m_sz;
  logic [AW-1:0] m_faddr;
  bit            chk_en = 1'b0;

  function automatic int find(input logic [AW-1:0] a);
    foreach (m_tbl[i]) if (m_tbl[i] == a) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_tbl.delete();
      m_ovf = 0; m_drop = 0; m_dump = 0; m_ptr = 0;
      m_fvld = 0; m_fspare = 0; m_faddr = '0; m_fidx = 0;
      chk_en = 1'b1;
    end else begin
      m_hit = find(func_addr);
      m_sz  = m_tbl.size();
      m_fvld = func_req;
      if (func_req) begin
        m_faddr  = func_addr;
        m_fspare = (m_hit >= 0);
        m_fidx   = (m_hit >= 0) ? m_hit : 0;
      end
      if (clear) begin
        m_tbl.delete();
        m_ovf = 0; m_drop = 0; m_dump = 0; m_ptr = 0;
      end else if (m_dump) begin
        if (err_valid) m_drop = 1;
        if (dump_ready) begin
          if (m_ptr == m_sz - 1) begin m_dump = 0; m_ptr = 0; end
          else m_ptr++;
        end
      end else begin
        if (err_valid && find(err_addr) < 0) begin
          if (m_sz < D) m_tbl.push_back(err_addr);
          else m_ovf = 1;
        end
        if (dump_req && m_sz > 0) begin m_dump = 1; m_ptr = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("func_valid", 32'(func_valid), 32'(m_fvld));
      chk("func_addr_out", 32'(func_addr_out), 32'(m_faddr));
      chk("func_spare", 32'(func_spare), 32'(m_fspare));
      chk("func_spare_idx", 32'(func_spare_idx), 32'(m_fidx));
      chk("rep_cnt", 32'(rep_cnt), 32'(m_tbl.size()));
      chk("rep_full", 32'(rep_full), 32'(m_tbl.size() == D));
      chk("rep_ovf", 32'(rep_ovf), 32'(m_ovf));
      chk("err_drop", 32'(err_drop), 32'(m_drop));
      chk("dump_valid", 32'(dump_valid), 32'(m_dump));
      chk("dump_busy", 32'(dump_busy), 32'(m_dump));
      chk("dump_data", 32'(dump_data), m_dump ? 32'(m_tbl[m_ptr]) : 32'd0);
      chk("dump_last", 32'(dump_last), 32'(m_dump && m_ptr == m_tbl.size() - 1));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; clear = 0; err_valid = 0; func_req = 0; dump_req = 0; dump_ready = 0;
  endtask

  task automatic cap(input logic [AW-1:0] a);
    err_valid = 1; err_addr = a; tick(); err_valid = 0;
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
    return AW'($urandom);
  endfunction

  initial begin
    idle(); rst = 1; err_addr = '0; func_addr = '0;
    tick(); idle();
    chk("lit_rst_cnt", 32'(rep_cnt), 32'd0);
    chk("lit_rst_fvld", 32'(func_valid), 32'd0);
    chk("lit_rst_dvld", 32'(dump_valid), 32'd0);

    // Dedup: 0x012, 0x034, 0x012
    cap(9'h012); cap(9'h034); cap(9'h012);
    chk("lit_dedup_cnt", 32'(rep_cnt), 32'd2);
    chk("lit_dedup_ovf", 32'(rep_ovf), 32'd0);
    func_req = 1; func_addr = 9'h034; tick();
    chk("lit_e1_spare", 32'(func_spare), 32'd1);
    chk("lit_e1_idx", 32'(func_spare_idx), 32'd1);
    func_addr = 9'h012; tick();
    chk("lit_e0_idx", 32'(func_spare_idx), 32'd0);
    chk("lit_e0_spare", 32'(func_spare), 32'd1);
    idle();

    // Overflow with five distinct addresses
    clear = 1; tick(); idle();
    for (int k = 0; k < 5; k++) cap(AW'(256 + k));
    chk("lit_full_cnt", 32'(rep_cnt), 32'd4);
    chk("lit_full", 32'(rep_full), 32'd1);
    chk("lit_ovf", 32'(rep_ovf), 32'd1);
    func_req = 1; func_addr = 9'h104; tick();
    chk("lit_5th_valid", 32'(func_valid), 32'd1);
    chk("lit_5th_spare", 32'(func_spare), 32'd0);
    func_addr = 9'h103; tick();
    chk("lit_4th_idx", 32'(func_spare_idx), 32'd3);
    idle();

    // Same-cycle capture and lookup
    clear = 1; tick(); idle();
    err_valid = 1; err_addr = 9'h0A0; func_req = 1; func_addr = 9'h0A0; tick();
    chk("lit_same_valid", 32'(func_valid), 32'd1);
    chk("lit_same_spare", 32'(func_spare), 32'd0);
    err_valid = 0; tick();
    chk("lit_next_spare", 32'(func_spare), 32'd1);
    chk("lit_next_idx", 32'(func_spare_idx), 32'd0);
    idle();

    // Dump with two stalled cycles and an error during the dump
    clear = 1; tick(); idle();
    cap(9'h001); cap(9'h002); cap(9'h003);
    dump_req = 1; tick(); dump_req = 0;
    chk("lit_d0_valid", 32'(dump_valid), 32'd1);
    chk("lit_d0_data", 32'(dump_data), 32'h001);
    chk("lit_d0_last", 32'(dump_last), 32'd0);
    err_valid = 1; err_addr = 9'h1FF; tick(); err_valid = 0;
    chk("lit_stall1_data", 32'(dump_data), 32'h001);
    chk("lit_drop", 32'(err_drop), 32'd1);
    chk("lit_drop_cnt", 32'(rep_cnt), 32'd3);
    tick();
    chk("lit_stall2_data", 32'(dump_data), 32'h001);
    dump_ready = 1; tick();
    chk("lit_d1_data", 32'(dump_data), 32'h002);
    chk("lit_d1_last", 32'(dump_last), 32'd0);
    tick();
    chk("lit_d2_data", 32'(dump_data), 32'h003);
    chk("lit_d2_last", 32'(dump_last), 32'd1);
    tick();
    chk("lit_done_busy", 32'(dump_busy), 32'd0);
    chk("lit_done_valid", 32'(dump_valid), 32'd0);
    chk("lit_done_cnt", 32'(rep_cnt), 32'd3);
    idle();

    // Dump request on an empty table
    clear = 1; tick(); idle();
    dump_req = 1; tick();
    chk("lit_empty_valid", 32'(dump_valid), 32'd0);
    dump_req = 0; tick();
    chk("lit_empty_valid2", 32'(dump_valid), 32'd0);

    // Clear during the second beat
    for (int k = 1; k <= 5; k++) cap(AW'(k));
    dump_req = 1; dump_ready = 1; tick(); dump_req = 0;
    err_valid = 1; err_addr = 9'h1FF; tick(); err_valid = 0;
    chk("lit_beat2_data", 32'(dump_data), 32'h002);
    clear = 1; dump_ready = 0; tick(); clear = 0;
    chk("lit_clr_valid", 32'(dump_valid), 32'd0);
    chk("lit_clr_cnt", 32'(rep_cnt), 32'd0);
    chk("lit_clr_ovf", 32'(rep_ovf), 32'd0);
    chk("lit_clr_drop", 32'(err_drop), 32'd0);
    tick();
    chk("lit_clr_valid2", 32'(dump_valid), 32'd0);

    // Reset mid-dump also zeroes the lookup pipeline; clear does not
    cap(9'h007);
    func_req = 1; func_addr = 9'h007; dump_req = 1; tick(); dump_req = 0;
    chk("lit_pre_rst_spare", 32'(func_spare), 32'd1);
    rst = 1; tick(); rst = 0; func_req = 0;
    chk("lit_rst_fvld2", 32'(func_valid), 32'd0);
    chk("lit_rst_faddr", 32'(func_addr_out), 32'd0);
    chk("lit_rst_dvld2", 32'(dump_valid), 32'd0);
    cap(9'h007);
    func_req = 1; func_addr = 9'h007; tick();
    func_req = 0; clear = 1; tick(); clear = 0;
    chk("lit_clr_fvld", 32'(func_valid), 32'd0);
    chk("lit_clr_faddr", 32'(func_addr_out), 32'h007);
    chk("lit_clr_fspare", 32'(func_spare), 32'd1);
    idle();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 999) == 0);
      clear      = ($urandom_range(0, 149) == 0);
      err_valid  = ($urandom_range(0, 3) == 0);
      err_addr   = pick();
      func_req   = $urandom_range(0, 1) == 1;
      func_addr  = pick();
      dump_req   = ($urandom_range(0, 19) == 0);
      dump_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
